pll_reset_sequencer: RTL and testbench
======================================

// Module: pll_reset_sequencer
// PURPOSE
// - Sits between the board clock/PLL and the SoC core reset. Drives the PLL reset and
//   watches pll_locked. Deasserts core_reset only after lock has stayed stable for a set time.
// - Re-pulses the PLL reset when lock does not arrive in time. Re-asserts core_reset when lock is lost.
// - Replaces the direct "core reset = !pll_locked" connection.
// PARAMETERS
// - PLL_RST_CYCLES  16     cycles pll_rst is held high per reset pulse (>=1)
// - LOCK_TIMEOUT    65536  cycles in WAIT_LOCK before the PLL is reset again (>=1)
// - LOCK_STABLE     1024   cycles locked_s must stay continuously high before HOLD (>=1)
// - HOLD_CYCLES     256    extra cycles core_reset is held after stability (>=1)
// - CNT_W           17     cycle counter width; must hold max(all four parameters)-1
// PORTS
// - sys_clock    in   1  board oscillator clock; free-running and independent of the PLL
// - reset        in   1  asynchronous active-high reset
// - pll_locked   in   1  PLL lock flag; asynchronous to sys_clock
// - pll_rst      out  1  registered PLL reset request, active-high
// - core_reset   out  1  registered core reset, active-high; the core re-synchronises it to its own clock
// - seq_state    out  3  current state encoding (debug)
// - retry_count  out  4  count of PLL reset re-pulses; saturates at 15
// BEHAVIOUR
// - Single clock (sys_clock). reset is asynchronous and active-high.
// - While reset is high: state=PLL_RST, cnt=0, pll_rst=1, core_reset=1, retry_count=0,
//   seq_state=0, sync flops=0.
// - pll_locked passes through a 2-flop synchroniser to give locked_s.
// - All state, counter and output updates happen on the sys_clock rising edge.
// - States (seq_state encoding) and transitions:
//   - PLL_RST(0): pll_rst=1. When cnt==PLL_RST_CYCLES-1 -> WAIT_LOCK, cnt=0.
//   - WAIT_LOCK(1): pll_rst=0.
//     - If locked_s=1 -> STABLE, cnt=0.
//     - Else if cnt==LOCK_TIMEOUT-1 -> PLL_RST, cnt=0, retry_count+1 (saturating).
//   - STABLE(2):
//     - If locked_s=0 -> WAIT_LOCK, cnt=0. retry_count is unchanged.
//     - Else if cnt==LOCK_STABLE-1 -> HOLD, cnt=0.
//   - HOLD(3):
//     - If locked_s=0 -> WAIT_LOCK, cnt=0.
//     - Else if cnt==HOLD_CYCLES-1 -> RUN.
//   - RUN(4): cnt is frozen. If locked_s=0 -> lock-loss handling (see CONFIGURATION).
// - Outputs are registered from the next state:
//   - core_reset=0 only when next state is RUN.
//   - pll_rst=1 only when next state is PLL_RST.
// - Latency: count sys_clock edges from the first edge that samples pll_locked=1, with the
//   block in WAIT_LOCK. core_reset falls on edge LOCK_STABLE+HOLD_CYCLES+3 if lock holds throughout.
// - Lock loss: core_reset rises on the 3rd edge after pll_locked falls (2 synchroniser edges + 1).
// - Simultaneous events: locked_s dropping takes priority over counter expiry in STABLE and HOLD.
//   In WAIT_LOCK, locked_s=1 takes priority over timeout.
// - Reset mid-operation: asserting reset immediately (asynchronously) forces the reset values,
//   from any state.
// - Unused or out-of-range state encodings (5-7) -> PLL_RST on the next edge.
// CONFIGURATION
// - RST_SEQ_RELOCK_RETRY_EN defined: lock loss in RUN -> PLL_RST, cnt=0, retry_count+1
//   (saturating). The PLL is forcibly reset.
// - RST_SEQ_RELOCK_RETRY_EN undefined: lock loss in RUN -> WAIT_LOCK, cnt=0, pll_rst stays 0,
//   retry_count unchanged.
// - core_reset re-asserts on lock loss in both builds.
// TESTING (PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE=4, HOLD_CYCLES=8, CNT_W=6)
// - Power-up: release reset, raise pll_locked 10 cycles later
//   -> pll_rst=1 for exactly 4 cycles, then 0.
//   -> core_reset falls on edge 15 after the first edge sampling pll_locked=1; seq_state=4.
// - Timeout: hold pll_locked=0
//   -> pll_rst re-pulses for 4 cycles after every 32 WAIT_LOCK cycles; retry_count increments by 1 each time.
//   -> after 20 timeouts retry_count=15 (saturated); core_reset stays 1 throughout.
// - Glitch in STABLE: drop pll_locked for 1 cycle while cnt=2
//   -> seq_state returns to 1, then 2; full stability count restarts; retry_count unchanged; core_reset never drops.
// - Lock loss in RUN: drop pll_locked
//   -> core_reset=1 on the 3rd edge.
//   -> macro undefined: seq_state=1, pll_rst=0.
//   -> macro defined: seq_state=0, pll_rst=1 for 4 cycles, retry_count+1.
// - Reset mid-HOLD: assert reset between clock edges
//   -> pll_rst=1, core_reset=1, seq_state=0, retry_count=0 before the next edge.
//   -> full sequence repeats after release.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// PLL reset / core reset sequencer: pulses the PLL reset, waits for a stable lock, then releases core_reset.
// Optional RST_SEQ_RELOCK_RETRY_EN: lock loss in RUN forces a fresh PLL reset pulse instead of a plain re-wait.
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int LOCK_STABLE    = 1024,
  parameter int HOLD_CYCLES    = 256,
  parameter int CNT_W          = 17
) (
  input  logic       sys_clock,
  input  logic       reset,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       core_reset,
  output logic [2:0] seq_state,
  output logic [3:0] retry_count
);

  // state | meaning
  // PLL_RST   (0) | PLL reset pulse in progress
  // WAIT_LOCK (1) | waiting for lock, timeout triggers another pulse
  // STABLE    (2) | lock seen, must stay high for LOCK_STABLE cycles
  // HOLD      (3) | extra core reset hold after stability
  // RUN       (4) | core released, counter frozen
  localparam logic [2:0] S_PLL_RST   = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABLE    = 3'd2;
  localparam logic [2:0] S_HOLD      = 3'd3;
  localparam logic [2:0] S_RUN       = 3'd4;

  localparam logic [CNT_W-1:0] RST_TC    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_TC = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] HOLD_TC   = CNT_W'(HOLD_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]       retry_q, retry_d, retry_inc;
  logic             pll_rst_q, pll_rst_d;
  logic             core_reset_q, core_reset_d;
  logic             sync1_q, sync2_q;
  logic             locked_s;

  assign locked_s  = sync2_q;
  assign cnt_inc   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  assign retry_inc = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_PLL_RST;
      cnt_q        <= '0;
      retry_q      <= 4'd0;
      pll_rst_q    <= 1'b1;
      core_reset_q <= 1'b1;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      pll_rst_q    <= pll_rst_d;
      core_reset_q <= core_reset_d;
      sync1_q      <= pll_locked;
      sync2_q      <= sync1_q;
    end
  end

  // Lock loss wins over counter expiry; lock arrival wins over timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    case (state_q)
      S_PLL_RST: begin
        if (cnt_q == RST_TC) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_TC) begin
          state_d = S_PLL_RST;
          cnt_d   = '0;
          retry_d = retry_inc;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_STABLE: begin
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_TC) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_HOLD: begin
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_TC) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RUN: begin
        if (!locked_s) begin
`ifdef RST_SEQ_RELOCK_RETRY_EN
          state_d = S_PLL_RST;
          retry_d = retry_inc;
`else
          state_d = S_WAIT_LOCK;
`endif
          cnt_d = '0;
        end
      end
      default: begin
        state_d = S_PLL_RST;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    pll_rst_d    = (state_d == S_PLL_RST);
    core_reset_d = (state_d != S_RUN);
  end

  assign pll_rst     = pll_rst_q;
  assign core_reset  = core_reset_q;
  assign seq_state   = state_q;
  assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small timing parameters.
module tb_pll_reset_sequencer;

`ifdef RST_SEQ_RELOCK_RETRY_EN
  localparam int RELOCK_RETRY = 1;
`else
  localparam int RELOCK_RETRY = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       locked;
  logic       pll_rst;
  logic       core_reset;
  logic [2:0] seq_state;
  logic [3:0] retry_count;

  int n_pass = 0;
  int n_chk  = 0;
  int n_fail = 0;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT  (32),
    .LOCK_STABLE   (4),
    .HOLD_CYCLES   (8),
    .CNT_W         (6)
  ) dut (
    .sys_clock  (clk),
    .reset      (rst),
    .pll_locked (locked),
    .pll_rst    (pll_rst),
    .core_reset (core_reset),
    .seq_state  (seq_state),
    .retry_count(retry_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst    = 1'b1;
    locked = 1'b0;
    repeat (3) tick;
    chk("rst_pll_rst", 8'(pll_rst), 8'd1);
    chk("rst_core", 8'(core_reset), 8'd1);
    chk("rst_state", 8'(seq_state), 8'd0);
    chk("rst_retry", 8'(retry_count), 8'd0);

    // power-up: four pll_rst cycles, lock raised 10 cycles after release
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick;
      chk("pwr_pll_rst", 8'(pll_rst), 8'((k < 4) ? 1 : 0));
      chk("pwr_state_a", 8'(seq_state), 8'((k < 4) ? 0 : 1));
      chk("pwr_core_a", 8'(core_reset), 8'd1);
    end
    repeat (6) tick;
    locked = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick;
      chk("pwr_core", 8'(core_reset), 8'((k < 15) ? 1 : 0));
      chk("pwr_state", 8'(seq_state),
          8'((k <= 2) ? 1 : (k <= 6) ? 2 : (k <= 14) ? 3 : 4));
      chk("pwr_pll_rst_lo", 8'(pll_rst), 8'd0);
    end
    chk("pwr_retry", 8'(retry_count), 8'd0);

    // lock loss in RUN
    locked = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick;
      chk("loss_core", 8'(core_reset), 8'((k == 3) ? 1 : 0));
    end
`ifdef RST_SEQ_RELOCK_RETRY_EN
    chk("loss_state", 8'(seq_state), 8'd0);
    chk("loss_pll_rst", 8'(pll_rst), 8'd1);
    chk("loss_retry", 8'(retry_count), 8'd1);
    for (int k = 4; k <= 7; k++) begin
      tick;
      chk("loss_pulse", 8'(pll_rst), 8'((k < 7) ? 1 : 0));
      chk("loss_pulse_state", 8'(seq_state), 8'((k < 7) ? 0 : 1));
    end
`else
    chk("loss_state", 8'(seq_state), 8'd1);
    chk("loss_pll_rst", 8'(pll_rst), 8'd0);
    chk("loss_retry", 8'(retry_count), 8'd0);
`endif

    // one-cycle lock glitch reaching the FSM while STABLE count is 2
    locked = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      tick;
      chk("glitch_state", 8'(seq_state),
          8'((k <= 2) ? 1 : (k <= 5) ? 2 : (k == 6) ? 1 : (k <= 10) ? 2 : (k <= 18) ? 3 : 4));
      chk("glitch_core", 8'(core_reset), 8'((k < 19) ? 1 : 0));
      chk("glitch_retry", 8'(retry_count), 8'(RELOCK_RETRY));
      if (k == 3) locked = 1'b0;
      if (k == 4) locked = 1'b1;
    end

    // repeated lock timeouts from a clean reset, retry saturates at 15
    locked = 1'b0;
    rst    = 1'b1;
    #2;
    rst    = 1'b0;
    for (int e = 1; e <= 720; e++) begin
      tick;
      chk("to_pll_rst", 8'(pll_rst), 8'(((e % 36) <= 3) ? 1 : 0));
      chk("to_retry", 8'(retry_count), 8'(((e / 36) > 15) ? 15 : (e / 36)));
      chk("to_core", 8'(core_reset), 8'd1);
    end

    // reset asserted between edges while in HOLD
    locked = 1'b1;
    repeat (10) tick;
    chk("hold_state", 8'(seq_state), 8'd3);
    chk("hold_retry", 8'(retry_count), 8'd15);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_pll_rst", 8'(pll_rst), 8'd1);
    chk("midrst_core", 8'(core_reset), 8'd1);
    chk("midrst_state", 8'(seq_state), 8'd0);
    chk("midrst_retry", 8'(retry_count), 8'd0);
    #1;
    rst = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      tick;
      chk("rerun_state", 8'(seq_state),
          8'((k <= 3) ? 0 : (k == 4) ? 1 : (k <= 8) ? 2 : (k <= 16) ? 3 : 4));
      chk("rerun_core", 8'(core_reset), 8'((k < 17) ? 1 : 0));
      chk("rerun_pll_rst", 8'(pll_rst), 8'((k <= 3) ? 1 : 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
